// File: rtl/pc_ras_unit_if.sv
// rtl/pc_ras_unit_if.sv - control/observation bundle for the PC + return-address-stack unit
interface pc_ras_unit_if #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic             freeze;
  logic             exc;
  logic [WIDTH-1:0] exc_vec;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] ret_target;
  logic             br_taken;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_next;
  logic [CW-1:0]    ras_count;
  logic             ras_overflow;
  logic             ras_underflow;

  modport master (
    output freeze, exc, exc_vec, call, ret, ret_target, br_taken, br_target,
    input  pc, pc_next, ras_count, ras_overflow, ras_underflow
  );

  modport slave (
    input  freeze, exc, exc_vec, call, ret, ret_target, br_taken, br_target,
    output pc, pc_next, ras_count, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_ras_unit.sv
// rtl/pc_ras_unit.sv - program counter with prioritised next-PC select and circular return-address stack
module pc_ras_unit #(
  parameter int               WIDTH     = 32,
  parameter int               INC       = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  pc_ras_unit_if.slave  bus
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] pc_q, pc_n;
  logic [PW-1:0]    ptr_q, ptr_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic             ovf_q, ovf_n;
  logic             unf_q, unf_n;
  logic [WIDTH-1:0] stack_q [RAS_DEPTH];
  logic             wr_en;
  logic [PW-1:0]    wr_idx;
  logic [WIDTH-1:0] seq_pc;

  assign seq_pc = pc_q + WIDTH'(INC);

  always_comb begin
    pc_n   = seq_pc;
    ptr_n  = ptr_q;
    cnt_n  = cnt_q;
    ovf_n  = 1'b0;
    unf_n  = 1'b0;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (bus.freeze) begin
      pc_n = pc_q;
    end else if (bus.exc) begin
      pc_n  = bus.exc_vec;
      cnt_n = '0;
      ptr_n = '0;
    end else if (bus.call && bus.ret) begin
      // Tail call: the new link replaces the current top rather than growing the stack
      pc_n  = bus.br_target;
      wr_en = 1'b1;
      if (cnt_q == '0) begin
        wr_idx = ptr_q + PW'(1);
        ptr_n  = ptr_q + PW'(1);
        cnt_n  = CW'(1);
      end
    end else if (bus.call) begin
      pc_n   = bus.br_target;
      wr_en  = 1'b1;
      wr_idx = ptr_q + PW'(1);
      ptr_n  = ptr_q + PW'(1);
      if (cnt_q == CW'(RAS_DEPTH)) ovf_n = 1'b1;
      else                         cnt_n = cnt_q + CW'(1);
    end else if (bus.ret) begin
      if (cnt_q != '0) begin
        pc_n  = stack_q[ptr_q];
        ptr_n = ptr_q - PW'(1);
        cnt_n = cnt_q - CW'(1);
      end else begin
        pc_n  = bus.ret_target;
        unf_n = 1'b1;
      end
    end else if (bus.br_taken) begin
      pc_n = bus.br_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q  <= RESET_VEC;
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      pc_q  <= pc_n;
      ptr_q <= ptr_n;
      cnt_q <= cnt_n;
      ovf_q <= ovf_n;
      unf_q <= unf_n;
      if (wr_en) stack_q[wr_idx] <= seq_pc;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.pc_next       = pc_n;
  assign bus.ras_count     = cnt_q;
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = unf_q;
endmodule
